fp_divider: RTL and testbench

//  Sequential IEEE-754 single-precision divider z = x / y for the RISC5 FPU (FDV).

---
 rtl/fp_pkg.sv | 15 +
 rtl/fp_div_step.sv | 25 ++
 rtl/fp_divider.sv | 93 +++++++++
 tb/tb_fp_divider.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants for the RISC5 FPU single-precision blocks.
//   EXP_BIAS        IEEE single exponent bias
//   FP_INF_EXP      all-ones exponent used for the infinity encoding
//   SIGN_BIT, EXP_MSB, EXP_LSB   field positions inside a 32-bit word
//   DIV_STEPS       quotient bits produced by the sequential divider
package fp_pkg;

  localparam int unsigned EXP_BIAS   = 127;
  localparam logic [7:0]  FP_INF_EXP = 8'hFF;
  localparam int unsigned SIGN_BIT   = 31;
  localparam int unsigned EXP_MSB    = 30;
  localparam int unsigned EXP_LSB    = 23;
  localparam int unsigned DIV_STEPS  = 25;

endpackage : fp_pkg

// File: rtl/fp_div_step.sv
// One restoring-division step (combinational).
//   r_in   [MW:0]   partial remainder entering this step
//   ym     [MW-1:0] divisor mantissa with hidden one
//   q_bit           quotient bit: 1 when r_in >= ym
//   r_next [MW:0]   remainder for the next step, already shifted left
module fp_div_step #(
  parameter int unsigned MW = 24
) (
  input  logic [MW:0]   r_in,
  input  logic [MW-1:0] ym,
  output logic          q_bit,
  output logic [MW:0]   r_next
);

  logic [MW+1:0] diff;
  logic [MW:0]   sel;

  always_comb begin
    diff   = {1'b0, r_in} - {2'b00, ym};
    q_bit  = ~diff[MW+1];
    sel    = q_bit ? diff[MW:0] : r_in;
    r_next = sel << 1;
  end

endmodule : fp_div_step

// File: rtl/fp_divider.sv
// Sequential IEEE-754 single-precision divider z = x / y (FDV).
// Restoring division, one quotient bit per clock, truncating, no denormals.
//   clk    clock
//   rst    synchronous active-high reset
//   run    divide request, held with x/y stable until stall falls
//   x, y   dividend and divisor (IEEE single)
//   stall  high while run is asserted and the quotient is not yet ready
//   z      quotient, valid when run=1 and stall=0
module fp_divider
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MANT_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic [EXP_W+MANT_W:0]   x,
  input  logic [EXP_W+MANT_W:0]   y,
  output logic                    stall,
  output logic [EXP_W+MANT_W:0]   z
);

  localparam int unsigned MW = MANT_W + 1;              // mantissa incl. hidden one
  localparam int unsigned SW = $clog2(DIV_STEPS + 1);   // step counter width
  localparam int unsigned EW = EXP_W + 2;               // signed exponent width
  localparam logic [SW-1:0] LAST = SW'(DIV_STEPS);

  logic [SW-1:0] s;
  logic [MW:0]   r;
  logic [MW:0]   q;

  logic [MW-1:0] xm, ym;
  logic [MW:0]   r_in, r_next;
  logic          q_bit;

  assign xm    = {1'b1, x[MANT_W-1:0]};
  assign ym    = {1'b1, y[MANT_W-1:0]};
  assign r_in  = (s == '0) ? {1'b0, xm} : r;
  assign stall = run & (s != LAST);

  fp_div_step #(.MW(MW)) u_step (
    .r_in   (r_in),
    .ym     (ym),
    .q_bit  (q_bit),
    .r_next (r_next)
  );

  // Counter saturates at LAST while run is held, freezing R/Q so z stays
  // stable; dropping run returns to step 0 and leaves R/Q untouched, since
  // a new divide reloads R from xm and shifts every old Q bit out.
  always_ff @(posedge clk) begin
    if (rst) begin
      s <= '0;
      r <= '0;
      q <= '0;
    end else if (run) begin
      if (s != LAST) begin
        s <= s + 1'b1;
        r <= r_next;
        q <= {q[MW-1:0], q_bit};
      end
    end else begin
      s <= '0;
    end
  end

  logic                  sgn;
  logic [EXP_W-1:0]      xe, ye;
  logic signed [EW-1:0]  e;
  logic [MANT_W-1:0]     mant;

  always_comb begin
    sgn  = x[SIGN_BIT] ^ y[SIGN_BIT];
    xe   = x[EXP_MSB:EXP_LSB];
    ye   = y[EXP_MSB:EXP_LSB];
    // Quotient lies in [1/2, 2): top bit set means one extra exponent step.
    e    = $signed({2'b00, xe} - {2'b00, ye} + EW'(EXP_BIAS - 1) + {{(EW-1){1'b0}}, q[MW]});
    mant = q[MW] ? q[MW-1:1] : q[MANT_W-1:0];

    if (x[EXP_MSB:0] == '0)
      z = '0;
    else if (y[EXP_MSB:0] == '0)
      z = {sgn, FP_INF_EXP, {MANT_W{1'b0}}};
    else if (e <= 0)
      z = '0;
    else if (e >= 255)
      z = {sgn, FP_INF_EXP, {MANT_W{1'b0}}};
    else
      z = {sgn, e[EXP_W-1:0], mant};
  end

endmodule : fp_divider

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: expected quotients are queued when a
// divide is launched and compared when the DUT drops stall.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [31:0] x   = '0;
  logic [31:0] y   = '0;
  logic        stall;
  logic [31:0] z;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] sb[$];
  int unsigned cnt  = 0;
  bit          done = 1'b0;

  fp_divider #(.EXP_W(8), .MANT_W(23)) dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .x     (x),
    .y     (y),
    .stall (stall),
    .z     (z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference: exact integer quotient of the scaled mantissas, then pack.
  function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] num, den, qq;
    logic        sg;
    int          e;
    sg = a[31] ^ b[31];
    if (a[30:0] == 31'd0) return 32'h0;
    if (b[30:0] == 31'd0) return {sg, 8'hFF, 23'h0};
    num = {40'd0, 1'b1, a[22:0]} << 24;
    den = {40'd0, 1'b1, b[22:0]};
    qq  = num / den;
    e   = int'(a[30:23]) - int'(b[30:23]) + 126 + int'(qq[24]);
    if (e <= 0)   return 32'h0;
    if (e >= 255) return {sg, 8'hFF, 23'h0};
    return {sg, e[7:0], qq[24] ? qq[23:1] : qq[22:0]};
  endfunction

  // Monitor: counts stall cycles of the current request, checks on completion.
  always @(negedge clk) begin
    if (rst || !run) begin
      cnt  = 0;
      done = 1'b0;
    end else if (stall) begin
      cnt++;
    end else if (!done) begin
      done = 1'b1;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        chk("z", z, sb.pop_front());
        chk("stall_len", 32'(cnt), 32'd25);
      end
    end
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input bit push,
                        input logic [31:0] exp);
    @(posedge clk); #1;
    x = a; y = b; run = 1'b1;
    if (push) sb.push_back(exp);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic drop_run();
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  task automatic div_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    launch(a, b, 1'b1, exp);
    wait_done();
    drop_run();
  endtask

  initial begin
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", {31'd0, stall}, 32'd0);

    // Directed vectors
    launch(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000);
    wait_done();
    // Saturation: hold run, result must stay put with stall low
    repeat (3) @(negedge clk);
    chk("sat_stall", {31'd0, stall}, 32'd0);
    chk("sat_z", z, 32'h40400000);
    drop_run();

    div_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA);
    div_op(32'hC1000000, 32'h40000000, 32'hC0800000);
    div_op(32'h3F800000, 32'h80000000, 32'hFF800000);
    div_op(32'h00000000, 32'h40400000, 32'h00000000);
    div_op(32'h00800000, 32'h40000000, 32'h00000000);
    div_op(32'h7F000000, 32'h3F000000, 32'h7F800000);

    // Reset at cycle 10 with run held: full restart after reset
    launch(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000);
    repeat (10) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    wait_done();
    drop_run();

    // Abandoned divide at cycle 12, then a fresh one
    launch(32'h41200000, 32'h40400000, 1'b0, 32'h0);
    repeat (12) @(negedge clk);
    drop_run();
    div_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA);

    // Back-to-back with a single run-low cycle between (div_op drops run once)
    div_op(32'h40C00000, 32'h40000000, 32'h40400000);
    div_op(32'hC1000000, 32'h40000000, 32'hC0800000);

    // Random operands against the reference model
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      div_op(ra, rb, model_div(ra, rb));
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule : tb_fp_divider
